// File: rtl/br_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters, a two-stage
// commit update path, and combinational prediction that forwards the update in flight.

module br_bht_ctr #(
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       we,
  input  logic [1:0] d,
  output logic [1:0] q
);
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)  q <= INIT_STATE;
    else if (we) q <= d;
  end
endmodule

module br_predictor #(
  parameter int         BHT_IDX_WIDTH = 8,
  parameter logic [1:0] INIT_STATE    = 2'b01
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        valid_from_rob_bus,
  input  logic [31:0] pc_from_rob_bus,
  input  logic        is_taken_from_rob_bus,
  input  logic [31:0] pc_from_inst_fetcher,
  output logic        is_taken_to_inst_fetcher,
  output logic [31:0] update_cnt,
  output logic [31:0] taken_cnt
);
  localparam int ENTRIES = 1 << BHT_IDX_WIDTH;

  typedef struct packed {
    logic                     vld;
    logic [BHT_IDX_WIDTH-1:0] idx;
    logic                     taken;
  } upd_t;

  upd_t                         s1;
  logic [ENTRIES-1:0][1:0]      bht;
  logic [ENTRIES-1:0]           bht_we;
  logic [1:0]                   s2_cur, s2_nxt;
  logic [BHT_IDX_WIDTH-1:0]     q_idx;
  logic                         q_fwd;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    else   return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Stage 1: capture the committed outcome; a stalled cycle drops the bus.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      s1 <= '0;
    else if (rdy_in)
      s1 <= '{vld:   valid_from_rob_bus,
              idx:   pc_from_rob_bus[BHT_IDX_WIDTH+1:2],
              taken: is_taken_from_rob_bus};
  end

  // Stage 2 reads the registered table directly: a write on the previous
  // edge is already visible, so back-to-back updates to one entry chain.
  assign s2_cur = bht[s1.idx];
  assign s2_nxt = sat_step(s2_cur, s1.taken);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_bht
    assign bht_we[g] = rdy_in && s1.vld && (s1.idx == BHT_IDX_WIDTH'(g));
    br_bht_ctr #(.INIT_STATE(INIT_STATE)) u_ctr (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .we     (bht_we[g]),
      .d      (s2_nxt),
      .q      (bht[g])
    );
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      update_cnt <= '0;
      taken_cnt  <= '0;
    end else if (rdy_in && s1.vld) begin
      update_cnt <= update_cnt + 32'd1;
      if (s1.taken) taken_cnt <= taken_cnt + 32'd1;
    end
  end

  assign q_idx = pc_from_inst_fetcher[BHT_IDX_WIDTH+1:2];
  assign q_fwd = s1.vld && (s1.idx == q_idx);
  assign is_taken_to_inst_fetcher = q_fwd ? s2_nxt[1] : bht[q_idx][1];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_from_rob_bus[31:BHT_IDX_WIDTH+2], pc_from_rob_bus[1:0],
                            pc_from_inst_fetcher[31:BHT_IDX_WIDTH+2], pc_from_inst_fetcher[1:0]};
endmodule

// File: tb/tb_br_predictor.sv
// Directed bench for br_predictor: counter walks, saturation, forwarding,
// aliasing, stall hold and reset-mid-update.

module tb_br_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        vld = 1'b0;
  logic [31:0] rob_pc = '0;
  logic        rob_taken = 1'b0;
  logic [31:0] fetch_pc = 32'h0000_1000;
  logic        pred;
  logic [31:0] update_cnt, taken_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  br_predictor #(.BHT_IDX_WIDTH(8), .INIT_STATE(2'b01)) dut (
    .clk_in                   (clk),
    .rst_in                   (rst),
    .rdy_in                   (rdy),
    .valid_from_rob_bus       (vld),
    .pc_from_rob_bus          (rob_pc),
    .is_taken_from_rob_bus    (rob_taken),
    .pc_from_inst_fetcher     (fetch_pc),
    .is_taken_to_inst_fetcher (pred),
    .update_cnt               (update_cnt),
    .taken_cnt                (taken_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp);
    fetch_pc = pc;
    #1;
    chk(tag, {31'd0, pred}, {31'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input int u, input int t);
    chk({tag, "_upd"}, update_cnt, u);
    chk({tag, "_tkn"}, taken_cnt, t);
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic t);
    vld = v; rob_pc = pc; rob_taken = t;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset with a valid commit on the bus; it must be ignored.
    step(1'b1, 32'h100, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    chk_pred("rst_pred", 32'h0000_1000, 1'b0);
    chk_pred("rst_pred_100", 32'h100, 1'b0);
    chk_cnt("rst", 0, 0);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    chk_cnt("post_rst", 0, 0);

    // Three taken commits to entry 0x40: 01->10->11->11.
    step(1'b1, 32'h100, 1'b1);
    chk_pred("fwd_first_taken", 32'h100, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk_pred("sat_hi_pred", 32'h100, 1'b1);
    chk_cnt("taken3", 3, 3);

    // Two not-taken: 11->10->01.
    step(1'b1, 32'h100, 1'b0);
    chk_pred("nt1_fwd", 32'h100, 1'b1);
    step(1'b1, 32'h100, 1'b0);
    chk_pred("nt2_fwd", 32'h100, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk_pred("nt2_tbl", 32'h100, 1'b0);
    // Two more to 00 (saturating), then one taken must give 01 (predict 0).
    step(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h100, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk_pred("sat_lo_pred", 32'h100, 1'b0);
    chk_cnt("walk", 8, 4);

    // Forward: query in the cycle the update sits in stage 1.
    fetch_pc = 32'h200;
    step(1'b1, 32'h200, 1'b1);
    chk_pred("fwd_200", 32'h200, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk_pred("tbl_200", 32'h200, 1'b1);
    chk_cnt("fwd", 9, 5);

    // Aliasing: 0x004 and 0x404 share index 1; index 2 is untouched.
    step(1'b1, 32'h004, 1'b1);
    step(1'b1, 32'h004, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk_pred("alias_404", 32'h404, 1'b1);
    chk_pred("neighbour_008", 32'h008, 1'b0);
    chk_cnt("alias", 11, 7);

    // Stall with an update in stage 1: it must wait, forward, then complete.
    step(1'b1, 32'h008, 1'b1);
    rdy = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk_pred("stall_fwd", 32'h008, 1'b1);
    chk_cnt("stall_s1", 11, 7);
    rdy = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    chk_cnt("stall_done", 12, 8);

    // Commits presented while stalled are dropped.
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 32'h008, 1'b1);
    chk_cnt("stall_drop", 12, 8);
    rdy = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk_cnt("stall_after", 12, 8);
    // Entry 2 must still be 10: one not-taken drops it to 01.
    step(1'b1, 32'h008, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk_pred("stall_tbl", 32'h008, 1'b0);
    chk_cnt("stall_nt", 13, 8);

    // Reset with an update pending in stage 1.
    step(1'b1, 32'h300, 1'b1);
    rst = 1'b1;
    vld = 1'b0;
    #1;
    chk_pred("rst_mid_300", 32'h300, 1'b0);
    chk_pred("rst_mid_004", 32'h004, 1'b0);
    chk_cnt("rst_mid", 0, 0);
    step(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0);
    chk_pred("rst_rel_300", 32'h300, 1'b0);
    chk_pred("rst_rel_200", 32'h200, 1'b0);
    chk_cnt("rst_rel", 0, 0);

    // First update after reset is accepted immediately.
    step(1'b1, 32'h300, 1'b1);
    chk_pred("first_upd_fwd", 32'h300, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk_cnt("first_upd", 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
